// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the NPC memory-side models.
package npc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;
    localparam int          LAT_W        = 3;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), shifts left once per enabled cycle.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] q
);

    logic [7:0] q_q, q_d;
    logic       fb;

    assign fb = q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3];

    always_comb begin
        q_d = q_q;
        if (en) q_d = {q_q[6:0], fb};
    end

    always_ff @(posedge clk) begin
        if (!rst) q_q <= SEED;
        else      q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/sram_resp.sv
// Single-request SRAM responder: holds each accepted request for L cycles in WAIT,
// then presents data/err with a one-cycle sram_valid in RESP.
module sram_resp
    import npc_mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = NPC_RESET_PC,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RAND_LAT    = 0,
    parameter int          FIX_LAT     = 1,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ren,
    input  logic        wen,
    input  logic [7:0]  wmask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] data,
    output logic        sram_valid,
    output logic        busy,
    output logic        err
);

    localparam int          IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    mem_state_t       state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    // captured request
    logic             wr_q, rd_q, rng_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wmask_q;

    logic             accept;
    logic [31:0]      off;
    logic             in_rng;
    logic [7:0]       lfsr_q;
    logic [LAT_W-1:0] lat_m1;
    logic             unused_ok;

    assign off    = addr - ADDR_BASE;
    assign in_rng = (addr >= ADDR_BASE) && ({2'b00, off[31:2]} < DEPTH_L);
    // RESP counts as free: a request held through RESP is taken on the edge that leaves it.
    assign accept = (state_q != WAIT) && (ren || wen);
    assign lat_m1 = (RAND_LAT != 0) ? lfsr_q[LAT_W-1:0] : LAT_W'(FIX_LAT - 1);

    assign unused_ok = ^{off[1:0], wmask[7:4], lfsr_q[7:LAT_W]};

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .q   (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = lat_m1;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == RESP);
        err_d   = (state_d == RESP) && !rng_q;
        data_d  = data_q;
        // Plain writes keep data; reads and read+write collisions load a new word.
        if (state_q == WAIT && state_d == RESP && (!wr_q || rd_q))
            data_d = (!wr_q && rng_q) ? mem[idx_q] : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= wen;
            rd_q    <= ren;
            rng_q   <= in_rng;
            idx_q   <= off[IDX_W+1:2];
            wdata_q <= wdata;
            wmask_q <= wmask[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst && state_q == RESP && wr_q && rng_q) begin
            for (int b = 0; b < 4; b++)
                if (wmask_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
    end

    assign data       = data_q;
    assign sram_valid = valid_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_sram_resp.sv
// Directed bench: three responders (fixed L=3, fixed L=1, LFSR latency) on one clock/reset.
module tb_sram_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ren   [3];
    logic        wen   [3];
    logic [7:0]  wmask [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] data  [3];
    logic        valid [3];
    logic        busy  [3];
    logic        err   [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_resp #(.FIX_LAT(3)) u_d3 (
        .clk(clk), .rst(rst), .ren(ren[0]), .wen(wen[0]), .wmask(wmask[0]),
        .addr(addr[0]), .wdata(wdata[0]), .data(data[0]), .sram_valid(valid[0]),
        .busy(busy[0]), .err(err[0]));

    sram_resp #(.FIX_LAT(1)) u_d1 (
        .clk(clk), .rst(rst), .ren(ren[1]), .wen(wen[1]), .wmask(wmask[1]),
        .addr(addr[1]), .wdata(wdata[1]), .data(data[1]), .sram_valid(valid[1]),
        .busy(busy[1]), .err(err[1]));

    sram_resp #(.RAND_LAT(1), .LFSR_SEED(8'hA5)) u_dr (
        .clk(clk), .rst(rst), .ren(ren[2]), .wen(wen[2]), .wmask(wmask[2]),
        .addr(addr[2]), .wdata(wdata[2]), .data(data[2]), .sram_valid(valid[2]),
        .busy(busy[2]), .err(err[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One request on instance k; returns cycles from accept edge to sram_valid.
    task automatic req(input int k, input logic r, input logic w, input logic [7:0] m,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] d, output logic e);
        @(negedge clk);
        ren[k] = r; wen[k] = w; wmask[k] = m; addr[k] = a; wdata[k] = wd;
        @(posedge clk);
        #1;
        ren[k] = 1'b0; wen[k] = 1'b0;
        chk("busy_after_accept", 32'(busy[k]), 32'd1);
        lat = 0;
        while (!valid[k] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!valid[k]) lat = 99;
        d = data[k];
        e = err[k];
    endtask

    typedef struct {
        logic        r, w;
        logic [7:0]  m;
        logic [31:0] a, wd, d;
        logic        e;
    } vec_t;

    vec_t        v [14];
    int          lat;
    logic [31:0] d;
    logic        e;
    logic [7:0]  ref_lfsr;
    int          hits;

    initial begin
        for (int k = 0; k < 3; k++) begin
            ren[k] = 1'b1; wen[k] = 1'b0; wmask[k] = 8'h0;
            addr[k] = 32'h8000_0000; wdata[k] = 32'h0;
        end

        // reset held two cycles with ren asserted
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk("rst_data", data[0], 32'h0);
            chk("rst_valid", 32'(valid[0]), 32'd0);
            chk("rst_busy", 32'(busy[0]), 32'd0);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) ren[k] = 1'b0;
        rst = 1'b1;

        v[0]  = '{1'b0, 1'b1, 8'h0F, 32'h8000_0000, 32'hA0A0_A0A0, 32'h0000_0000, 1'b0};
        v[1]  = '{1'b0, 1'b1, 8'h0F, 32'h8000_3FFC, 32'h5A5A_5A5A, 32'h0000_0000, 1'b0};
        v[2]  = '{1'b0, 1'b1, 8'h0F, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        v[3]  = '{1'b1, 1'b0, 8'h00, 32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        v[4]  = '{1'b0, 1'b1, 8'h05, 32'h8000_0010, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0};
        v[5]  = '{1'b1, 1'b0, 8'h00, 32'h8000_0010, 32'h0,         32'hDE22_BE44, 1'b0};
        v[6]  = '{1'b0, 1'b1, 8'hF0, 32'h8000_0010, 32'hFFFF_FFFF, 32'hDE22_BE44, 1'b0};
        v[7]  = '{1'b1, 1'b0, 8'h00, 32'h8000_0013, 32'h0,         32'hDE22_BE44, 1'b0};
        v[8]  = '{1'b1, 1'b0, 8'h00, 32'h7FFF_FFFC, 32'h0,         32'h0000_0000, 1'b1};
        v[9]  = '{1'b1, 1'b0, 8'h00, 32'h8000_4000, 32'h0,         32'h0000_0000, 1'b1};
        v[10] = '{1'b0, 1'b1, 8'h0F, 32'h7FFF_FFFC, 32'h1234_5678, 32'h0000_0000, 1'b1};
        v[11] = '{1'b0, 1'b1, 8'h0F, 32'h8000_4000, 32'h1234_5678, 32'h0000_0000, 1'b1};
        v[12] = '{1'b1, 1'b0, 8'h00, 32'h8000_3FFC, 32'h0,         32'h5A5A_5A5A, 1'b0};
        v[13] = '{1'b1, 1'b0, 8'h00, 32'h8000_0000, 32'h0,         32'hA0A0_A0A0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            req(0, v[i].r, v[i].w, v[i].m, v[i].a, v[i].wd, lat, d, e);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
            chk($sformatf("vec%0d_data", i), d, v[i].d);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(v[i].e));
        end

        // L=1 with ren held: one response every two cycles
        req(1, 1'b0, 1'b1, 8'h0F, 32'h8000_0020, 32'hCAFE_F00D, lat, d, e);
        chk("d1_wr_lat", 32'(lat), 32'd1);
        @(negedge clk);
        ren[1] = 1'b1; addr[1] = 32'h8000_0020;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold_valid%0d", i), 32'(valid[1]), 32'((i % 2) == 1));
            if (valid[1]) chk("hold_data", data[1], 32'hCAFE_F00D);
        end
        @(negedge clk);
        ren[1] = 1'b0;
        repeat (4) @(posedge clk);

        // read+write collision: write commits, response data is zero
        req(1, 1'b1, 1'b1, 8'h0F, 32'h8000_0020, 32'h0BAD_C0DE, lat, d, e);
        chk("conflict_lat", 32'(lat), 32'd1);
        chk("conflict_data", d, 32'h0);
        chk("conflict_err", 32'(e), 32'd0);
        req(1, 1'b1, 1'b0, 8'h00, 32'h8000_0020, 32'h0, lat, d, e);
        chk("conflict_rdback", d, 32'h0BAD_C0DE);

        // LFSR latency sequence against a reference
        ref_lfsr = 8'hA5;
        for (int i = 0; i < 64; i++) begin
            req(2, 1'b1, 1'b0, 8'h00, 32'h8000_0100, 32'h0, lat, d, e);
            chk($sformatf("rand_lat%0d", i), 32'(lat), 32'(ref_lfsr[2:0]) + 32'd1);
            ref_lfsr = {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
        end

        req(2, 1'b0, 1'b1, 8'h0F, 32'h8000_0040, 32'h1111_1111, lat, d, e);
        chk("pre_rst_wr_lat", 32'(lat), 32'(ref_lfsr[2:0]) + 32'd1);

        // reset while the next write is in WAIT
        @(negedge clk);
        wen[2] = 1'b1; wmask[2] = 8'h0F; addr[2] = 32'h8000_0040; wdata[2] = 32'h2222_2222;
        @(posedge clk);
        #1;
        wen[2] = 1'b0;
        chk("midrst_busy_before", 32'(busy[2]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_valid", 32'(valid[2]), 32'd0);
        chk("midrst_busy", 32'(busy[2]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        hits = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (valid[2]) hits++;
        end
        chk("midrst_no_valid", 32'(hits), 32'd0);
        // LFSR restarts at the seed: first latency is 1 + 3'b101
        req(2, 1'b1, 1'b0, 8'h00, 32'h8000_0040, 32'h0, lat, d, e);
        chk("midrst_lat", 32'(lat), 32'd6);
        chk("midrst_mem", d, 32'h1111_1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
